quad_encoder_gen: RTL and testbench

Quadrature generator: converts single-cycle Left/Right step requests into A/B quadrature waveforms equivalent to a rotary encoder turned by one detent per step. Used as an encoder emulator, for loopback self-test of the rotary-encoder decoder path, and to drive external quadrature inputs. Requests are accumulated in a signed net-step counter. Each step is emitted as two timed phase edges between the rest states AB=00 and AB=11.

---
 rtl/encoder_pkg.sv | 24 ++
 rtl/phase_timer.sv | 26 ++
 rtl/quad_encoder_gen.sv | 130 +++++++++++++
 tb/tb_quad_encoder_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder emulator.
package encoder_pkg;

    typedef enum logic [1:0] {
        G_IDLE   = 2'd0,
        G_FIRST  = 2'd1,
        G_SECOND = 2'd2
    } gen_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Net request for one cycle: right is +1, left is -1, both or neither cancel.
    function automatic logic signed [1:0] step_delta(input logic left, input logic right);
        logic signed [1:0] d;
        case ({left, right})
            2'b01:   d = 2'sd1;
            2'b10:   d = -2'sd1;
            default: d = 2'sd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Load-and-count-down hold timer; done while the count sits at zero.
module phase_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Load_Val,
    output logic             o_Done_c
);

    logic [WIDTH-1:0] r_Count;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_Count <= '0;
        end else if (i_Load) begin
            r_Count <= i_Load_Val;
        end else if (r_Count != '0) begin
            r_Count <= r_Count - WIDTH'(1);
        end
    end

    assign o_Done_c = (r_Count == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature generator: turns Left/Right step pulses into A/B detent waveforms,
// buffering requests in a saturating signed net-step counter.
module quad_encoder_gen
    import encoder_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 4,
    parameter int unsigned QUEUE_BITS   = 4
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic                         i_Left,
    input  logic                         i_Right,
    output logic                         o_A,
    output logic                         o_B,
    output logic                         o_Busy,
    output logic signed [QUEUE_BITS-1:0] o_Pending,
    output logic                         o_Overflow
);

    localparam int unsigned TW = $clog2(PHASE_CYCLES + 1);
    localparam int unsigned SW = QUEUE_BITS + 2;
    localparam logic signed [SW-1:0] MAX_P = SW'((1 << (QUEUE_BITS - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_P = -MAX_P;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(PHASE_CYCLES - 1);

    gen_state_t state, state_next;
    logic r_Dir, dir_next;
    logic r_A, a_next;
    logic r_B, b_next;
    logic r_Busy;
    logic r_Overflow, ovf_next;
    logic signed [QUEUE_BITS-1:0] r_Pending, pending_next;
    logic signed [1:0] req_delta, start_delta;
    logic signed [SW-1:0] sum_c;
    logic timer_load, timer_done_c;

    phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Load     (timer_load),
        .i_Load_Val (HOLD_LOAD),
        .o_Done_c   (timer_done_c)
    );

    // Step sequencer: first channel on start, second after one phase, idle after another.
    always_comb begin
        state_next  = state;
        dir_next    = r_Dir;
        a_next      = r_A;
        b_next      = r_B;
        timer_load  = 1'b0;
        start_delta = 2'sd0;
        case (state)
            G_IDLE: begin
                if (r_Pending != '0) begin
                    dir_next    = r_Pending[QUEUE_BITS-1] ? DIR_LEFT : DIR_RIGHT;
                    start_delta = r_Pending[QUEUE_BITS-1] ? -2'sd1 : 2'sd1;
                    if (dir_next == DIR_RIGHT) begin
                        a_next = ~r_A;
                    end else begin
                        b_next = ~r_B;
                    end
                    timer_load = 1'b1;
                    state_next = G_FIRST;
                end
            end
            G_FIRST: begin
                if (timer_done_c) begin
                    if (r_Dir == DIR_RIGHT) begin
                        b_next = ~r_B;
                    end else begin
                        a_next = ~r_A;
                    end
                    timer_load = 1'b1;
                    state_next = G_SECOND;
                end
            end
            G_SECOND: begin
                if (timer_done_c) begin
                    state_next = G_IDLE;
                end
            end
            default: state_next = G_IDLE;
        endcase
    end

    // Net-step accounting; only the incoming request is lost on saturation.
    always_comb begin
        req_delta    = step_delta(i_Left, i_Right);
        sum_c        = SW'(r_Pending) + SW'(req_delta) - SW'(start_delta);
        ovf_next     = r_Overflow;
        pending_next = QUEUE_BITS'(sum_c);
        if (sum_c > MAX_P) begin
            pending_next = QUEUE_BITS'(MAX_P);
            ovf_next     = 1'b1;
        end else if (sum_c < MIN_P) begin
            pending_next = QUEUE_BITS'(MIN_P);
            ovf_next     = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state      <= G_IDLE;
            r_Dir      <= DIR_RIGHT;
            r_A        <= 1'b0;
            r_B        <= 1'b0;
            r_Pending  <= '0;
            r_Overflow <= 1'b0;
            r_Busy     <= 1'b0;
        end else begin
            state      <= state_next;
            r_Dir      <= dir_next;
            r_A        <= a_next;
            r_B        <= b_next;
            r_Pending  <= pending_next;
            r_Overflow <= ovf_next;
            r_Busy     <= (state_next != G_IDLE) || (pending_next != '0);
        end
    end

    assign o_A        = r_A;
    assign o_B        = r_B;
    assign o_Busy     = r_Busy;
    assign o_Pending  = r_Pending;
    assign o_Overflow = r_Overflow;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: expected step directions are queued at stimulus
// time and consumed by a quadrature decoder monitor watching o_A/o_B.
module tb_quad_encoder_gen;
    import encoder_pkg::*;

    localparam int unsigned PH = 4;
    localparam int unsigned QB = 4;

    logic i_Clk = 1'b0;
    logic i_Rst_n = 1'b0;
    logic i_Left = 1'b0;
    logic i_Right = 1'b0;
    logic o_A, o_B, o_Busy, o_Overflow;
    logic signed [QB-1:0] o_Pending;

    quad_encoder_gen #(
        .PHASE_CYCLES(PH),
        .QUEUE_BITS  (QB)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Left     (i_Left),
        .i_Right    (i_Right),
        .o_A        (o_A),
        .o_B        (o_B),
        .o_Busy     (o_Busy),
        .o_Pending  (o_Pending),
        .o_Overflow (o_Overflow)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic exp_q[$];

    // Decoder monitor state
    int cyc = 0;
    int t_first = 0;
    int t_last = 0;
    int cnt_right = 0;
    int cnt_left = 0;
    int n_edges = 0;
    logic in_step = 1'b0;
    logic have_last = 1'b0;
    logic [1:0] mon_cur, prev_ab, rest_ab, mid_ab, end_exp, diff_ab;
    logic mon_dir, mon_exp;

    always @(negedge i_Clk) begin
        cyc++;
        mon_cur = {o_A, o_B};
        if (!i_Rst_n) begin
            prev_ab   = mon_cur;
            in_step   = 1'b0;
            have_last = 1'b0;
        end else if (mon_cur != prev_ab) begin
            n_edges++;
            diff_ab = mon_cur ^ prev_ab;
            check("one_channel", int'(diff_ab == 2'b01 || diff_ab == 2'b10), 1);
            if (!in_step) begin
                check("start_at_rest", int'(prev_ab == 2'b00 || prev_ab == 2'b11), 1);
                if (have_last) check("idle_gap", int'((cyc - t_last) >= int'(PH + 1)), 1);
                rest_ab = prev_ab;
                mid_ab  = mon_cur;
                t_first = cyc;
                in_step = 1'b1;
            end else begin
                end_exp = ~rest_ab;
                check("phase_len", cyc - t_first, int'(PH));
                check("rest_end", int'(mon_cur), int'(end_exp));
                mon_dir = ((rest_ab == 2'b00 && mid_ab == 2'b10) ||
                           (rest_ab == 2'b11 && mid_ab == 2'b01)) ? DIR_RIGHT : DIR_LEFT;
                if (mon_dir == DIR_RIGHT) cnt_right++;
                else cnt_left++;
                if (exp_q.size() == 0) begin
                    check("unexpected_step", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("step_dir", int'(mon_dir), int'(mon_exp));
                end
                in_step   = 1'b0;
                t_last    = cyc;
                have_last = 1'b1;
            end
            prev_ab = mon_cur;
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (o_Busy && n < max_cycles) begin
            tick();
            n++;
        end
        if (o_Busy) check("idle_timeout", 1, 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, l0, e0;

        // Reset
        i_Rst_n = 1'b0;
        repeat (3) tick();
        i_Rst_n = 1'b1;
        check("rst_a", int'(o_A), 0);
        check("rst_b", int'(o_B), 0);
        check("rst_pending", int'(o_Pending), 0);
        check("rst_busy", int'(o_Busy), 0);
        check("rst_ovf", int'(o_Overflow), 0);
        tick();

        // Single right step from AB=00
        r0 = cnt_right; l0 = cnt_left;
        exp_q.push_back(DIR_RIGHT);
        i_Right = 1'b1;
        tick();
        i_Right = 1'b0;
        check("t1_pend_e0", int'(o_Pending), 1);
        check("t1_a_e0", int'(o_A), 0);
        tick();
        check("t1_a_e1", int'(o_A), 1);
        check("t1_b_e1", int'(o_B), 0);
        repeat (3) tick();
        check("t1_a_e4", int'(o_A), 1);
        check("t1_b_e4", int'(o_B), 0);
        tick();
        check("t1_b_e5", int'(o_B), 1);
        repeat (3) tick();
        check("t1_busy_e8", int'(o_Busy), 1);
        tick();
        check("t1_busy_e9", int'(o_Busy), 0);
        tick();
        check("t1_right_pulses", cnt_right - r0, 1);
        check("t1_left_pulses", cnt_left - l0, 0);

        // Left step from AB=11
        r0 = cnt_right; l0 = cnt_left;
        exp_q.push_back(DIR_LEFT);
        i_Left = 1'b1;
        tick();
        i_Left = 1'b0;
        tick();
        check("t2_b_e1", int'(o_B), 0);
        check("t2_a_e1", int'(o_A), 1);
        repeat (3) tick();
        check("t2_a_e4", int'(o_A), 1);
        tick();
        check("t2_a_e5", int'(o_A), 0);
        check("t2_b_e5", int'(o_B), 0);
        wait_idle(50);
        check("t2_left_pulses", cnt_left - l0, 1);
        check("t2_right_pulses", cnt_right - r0, 0);

        // Simultaneous left and right cancel
        e0 = n_edges;
        i_Left = 1'b1; i_Right = 1'b1;
        tick();
        i_Left = 1'b0; i_Right = 1'b0;
        check("t3_pend", int'(o_Pending), 0);
        check("t3_busy", int'(o_Busy), 0);
        repeat (4) tick();
        check("t3_busy_late", int'(o_Busy), 0);
        check("t3_edges", n_edges - e0, 0);

        // Burst of 10 right requests saturates at +7
        r0 = cnt_right;
        for (int i = 0; i < 8; i++) exp_q.push_back(DIR_RIGHT);
        for (int k = 0; k < 10; k++) begin
            i_Right = 1'b1;
            tick();
            if (k == 7) check("t4_ovf_e7", int'(o_Overflow), 0);
            if (k == 8) check("t4_ovf_e8", int'(o_Overflow), 1);
            if (k >= 7) check("t4_pend_sat", int'(o_Pending), 7);
        end
        i_Right = 1'b0;
        wait_idle(200);
        check("t4_right_pulses", cnt_right - r0, 8);
        check("t4_ovf_sticky", int'(o_Overflow), 1);
        check("t4_queue_empty", exp_q.size(), 0);

        // Three right, one left, then reset mid-way through the second step
        exp_q.push_back(DIR_RIGHT);
        exp_q.push_back(DIR_RIGHT);
        for (int k = 0; k < 4; k++) begin
            i_Right = (k < 3);
            i_Left  = (k == 3);
            tick();
        end
        i_Right = 1'b0; i_Left = 1'b0;
        check("t5_pend_e3", int'(o_Pending), 1);
        repeat (6) tick();
        check("t5_ab_e9", int'({o_A, o_B}), 3);
        check("t5_busy_e9", int'(o_Busy), 1);
        tick();
        check("t5_ab_e10", int'({o_A, o_B}), 1);
        check("t5_pend_e10", int'(o_Pending), 0);
        tick();
        check("t5_queue_left", exp_q.size(), 1);
        i_Rst_n = 1'b0;
        tick();
        check("t5_rst_a", int'(o_A), 0);
        check("t5_rst_b", int'(o_B), 0);
        check("t5_rst_pend", int'(o_Pending), 0);
        check("t5_rst_busy", int'(o_Busy), 0);
        check("t5_rst_ovf", int'(o_Overflow), 0);
        exp_q.delete();
        tick();
        i_Rst_n = 1'b1;
        e0 = n_edges;
        repeat (30) tick();
        check("t5_no_edges", n_edges - e0, 0);
        check("t5_ab_final", int'({o_A, o_B}), 0);
        check("t5_busy_final", int'(o_Busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
